// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and default bus widths.
// Imported by the requester, its interface and any slave models.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage : apb_pkg

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus signals for the apb_master block.
// Modports:
//   master - the requester's view (drives cmd_ready, rsp_*, psel/penable/pwrite/paddr/pwdata)
//   slave  - the sequencer/peripheral view (drives cmd_*, prdata, pready, pslverr)
interface apb_master_if #(
    parameter int unsigned ADDR_W = apb_pkg::APB_ADDR_W,
    parameter int unsigned DATA_W = apb_pkg::APB_DATA_W
);

    // local command side
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // response pulse
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface : apb_master_if

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter.
// Ports: clk, rst_n (async active-low), clear (restart count), inc (one more
// wait cycle), expired (this inc is the TIMEOUT-th consecutive wait cycle).
// TIMEOUT = 0 disables expiry.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CNT_W-1:0] count;

    // Counts up to TIMEOUT and holds there until the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(TIMEOUT))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Fires on the edge that would bring the count to TIMEOUT.
    assign expired = (TIMEOUT != 0) && inc && (count == CNT_W'(LAST));

endmodule : apb_wait_timer

// File: rtl/apb_master.sv
// Single-outstanding APB requester: accepts one local command, runs an APB
// SETUP/ACCESS transfer and returns a one-cycle response pulse, aborting
// with rsp_timeout if the slave holds pready low for TIMEOUT ACCESS cycles.
// Ports: pclk, prst (async active-low), bus (apb_master_if.master: cmd_*,
// rsp_*, psel/penable/pwrite/paddr/pwdata, prdata/pready/pslverr).
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = APB_ADDR_W,
    parameter int unsigned DATA_W  = APB_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          prst,
    apb_master_if.master  bus
);

    apb_state_t state, next_state;

    logic accept_c;
    logic complete_c;
    logic abort_c;
    logic wait_inc;
    logic timer_expired;

    logic              cmd_ready_q;
    logic              psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    // State register
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and transfer events
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        complete_c = 1'b0;
        abort_c    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept_c   = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                // completion wins over a timeout on the same edge
                if (bus.pready) begin
                    complete_c = 1'b1;
                    next_state = IDLE;
                end else if (timer_expired) begin
                    abort_c    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign wait_inc = (state == ACCESS) && !bus.pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (pclk),
        .rst_n   (prst),
        .clear   (accept_c),
        .inc     (wait_inc),
        .expired (timer_expired)
    );

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            cmd_ready_q <= (next_state == IDLE);
            psel_q      <= (next_state != IDLE);
            penable_q   <= (next_state == ACCESS);
        end
    end

    // Transfer attributes held from accept until the next accept.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else if (accept_c) begin
            pwrite_q <= bus.cmd_write;
            paddr_q  <= bus.cmd_addr;
            pwdata_q <= bus.cmd_wdata;
        end
    end

    // Response fields are zero outside the one-cycle pulse.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= complete_c || abort_c;
            rsp_err_q     <= (complete_c && bus.pslverr) || abort_c;
            rsp_timeout_q <= abort_c;
            rsp_rdata_q   <= (complete_c && !pwrite_q && !bus.pslverr) ? bus.prdata : '0;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule : apb_master

// File: tb/tb_apb_master.sv
// Directed self-checking bench for apb_master with a 16-entry APB register
// file slave model (addresses >= 16 answer with pslverr) and a programmable
// number of pready-low wait cycles per transfer.
module tb_apb_master;

    logic pclk = 1'b0;
    logic prst;

    always #5 pclk = ~pclk;

    apb_master_if bus ();

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (8),
        .TIMEOUT (16)
    ) dut (
        .pclk (pclk),
        .prst (prst),
        .bus  (bus.master)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // slave model
    logic [7:0] mem [16] = '{default: 8'h00};
    int wait_cfg = 0;
    int wait_cnt = 0;

    assign bus.pready  = (wait_cnt == 0);
    assign bus.pslverr = bus.psel && bus.penable && bus.pready && (bus.paddr >= 32'd16);
    assign bus.prdata  = (bus.paddr < 32'd16) ? mem[bus.paddr[3:0]] : 8'h00;

    always @(posedge pclk) begin
        if (bus.psel && !bus.penable) begin
            wait_cnt <= wait_cfg;
        end else if (bus.psel && bus.penable && !bus.pready) begin
            wait_cnt <= wait_cnt - 1;
        end
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && (bus.paddr < 32'd16)) begin
            mem[bus.paddr[3:0]] <= bus.pwdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command at posedge+1 and follow it to its response.
    // Latency counts cycles from the cycle cmd_valid is presented.
    task automatic run_cmd(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [7:0] wd, input int wt, input int poke,
                           input int exp_lat, input logic [7:0] exp_rd,
                           input logic exp_err, input logic exp_to);
        int lat;
        wait_cfg      = wt;
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        check({tag, "_setup_penable"}, 32'(bus.penable), 32'd0);
        while (!bus.rsp_valid && lat < 100) begin
            check({tag, "_psel"}, 32'(bus.psel), 32'd1);
            check({tag, "_paddr"}, bus.paddr, addr);
            check({tag, "_pwrite"}, 32'(bus.pwrite), 32'(wr));
            if (wr) check({tag, "_pwdata"}, 32'(bus.pwdata), 32'(wd));
            if (lat >= 2) check({tag, "_penable"}, 32'(bus.penable), 32'd1);
            if (lat == poke) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = ~wr;
                bus.cmd_addr  = 32'd9;
                check({tag, "_busy_ready"}, 32'(bus.cmd_ready), 32'd0);
            end
            @(posedge pclk);
            #1;
            bus.cmd_valid = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'(exp_to));
        check({tag, "_rsp_ready"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge pclk);
        #1;
        check({tag, "_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_psel_end"}, 32'(bus.psel), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_psel"}, 32'(bus.psel), 32'd0);
        check({tag, "_penable"}, 32'(bus.penable), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    endtask

    initial begin
        prst          = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        #12;
        check_quiet("reset");
        check("reset_pwrite", 32'(bus.pwrite), 32'd0);
        check("reset_paddr", bus.paddr, 32'd0);
        check("reset_pwdata", 32'(bus.pwdata), 32'd0);
        #10;
        prst = 1'b1;
        @(posedge pclk);
        #1;
        check("release_ready", 32'(bus.cmd_ready), 32'd1);

        run_cmd("wr3",    1'b1, 32'd3,  8'hA5, 0,    0, 3,  8'h00, 1'b0, 1'b0);
        run_cmd("rd3",    1'b0, 32'd3,  8'h00, 0,    0, 3,  8'hA5, 1'b0, 1'b0);
        run_cmd("wr20",   1'b1, 32'd20, 8'h55, 0,    0, 3,  8'h00, 1'b1, 1'b0);
        run_cmd("wr7",    1'b1, 32'd7,  8'h77, 0,    0, 3,  8'h00, 1'b0, 1'b0);
        run_cmd("rd7w3",  1'b0, 32'd7,  8'h00, 3,    3, 6,  8'h77, 1'b0, 1'b0);
        run_cmd("tmo",    1'b0, 32'd3,  8'h00, 1000, 0, 18, 8'h00, 1'b1, 1'b1);
        run_cmd("race",   1'b0, 32'd3,  8'h00, 15,   0, 18, 8'hA5, 1'b0, 1'b0);
        check("mem9_untouched", 32'(mem[9]), 32'd0);

        // reset while the slave stalls in ACCESS
        wait_cfg      = 1000;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd3;
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        check("pre_rst_penable", 32'(bus.penable), 32'd1);
        #3;
        prst = 1'b0;
        #1;
        check_quiet("midrst");
        @(posedge pclk);
        #1;
        check("midrst_held_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_held_psel", 32'(bus.psel), 32'd0);
        wait_cfg = 0;
        #3;
        prst = 1'b1;
        @(posedge pclk);
        #1;
        check("rerelease_ready", 32'(bus.cmd_ready), 32'd1);
        check("rerelease_valid", 32'(bus.rsp_valid), 32'd0);

        run_cmd("wr1",    1'b1, 32'd1,  8'h3C, 0,    0, 3,  8'h00, 1'b0, 1'b0);
        run_cmd("rd1",    1'b0, 32'd1,  8'h00, 0,    0, 3,  8'h3C, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_apb_master

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a local command handshake into APB SETUP/ACCESS transfers and returns read data and error status on a one-cycle response pulse. It sits between an on-chip controller or testbench sequencer and the APB peripheral slaves (8-bit data, 16-entry register file), driving `psel`/`penable` and sampling `pready`/`pslverr`. It adds a bounded wait-state timeout so a hung slave cannot stall the bus.

## Interface

**Parameters**
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 8: APB data width.
- `TIMEOUT`, 16: number of ACCESS cycles with `pready` low before abort; 0 disables the timeout.

**Ports**
- `pclk` in 1: single clock, rising edge.
- `prst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block accepts a command this cycle.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: `pslverr` seen, or timeout.
- `rsp_timeout` out 1: transfer aborted by timeout.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_W: APB address.
- `pwdata` out DATA_W: APB write data.
- `prdata` in DATA_W: APB read data.
- `pready` in 1: slave completion.
- `pslverr` in 1: slave error.

## Operation

**States** (IDLE, SETUP, ACCESS):
- **IDLE**
  - `cmd_ready = 1`.
  - When `cmd_valid && cmd_ready`, register write/addr/wdata and go to SETUP.
- **SETUP**
  - `psel = 1`, `penable = 0`.
  - Always goes to ACCESS after one cycle.
- **ACCESS**
  - `psel = 1`, `penable = 1`.
  - If `pready = 1`, the transfer completes:
    - capture `prdata` (reads only), `pslverr` → `rsp_err`;
    - next state is IDLE.
  - If `pready = 0`, increment the wait counter. If the counter reaches `TIMEOUT`, abort: go to IDLE with `rsp_err = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`.

**Rules**
- `cmd_ready` is 0 in SETUP and ACCESS. `cmd_valid` in those states is ignored, not queued.
- `paddr`, `pwrite`, `pwdata` are registered and stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- `rsp_valid` is not back-pressured. It pulses for exactly one cycle per accepted command, and the `rsp_*` fields are valid only during that pulse.
- `pslverr` is sampled only when `psel && penable && pready`.
- The master does no address-range checking; address decode belongs to the slave.
- The wait counter is cleared on entry to SETUP. It is sized `$clog2(TIMEOUT+1)` bits, never wraps, and saturates at the abort.

## Timing

- **Reset:** while `prst = 0`, state = IDLE. The registered outputs `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout` are all 0. `cmd_ready = 0` while in reset, and 1 from the first edge after release.
- **Command accepted at edge E0:**
  - SETUP during cycle E0→E1;
  - ACCESS from E1;
  - with zero wait states, completion at E2;
  - `rsp_valid` high during E2→E3, with `cmd_ready = 1` in the same cycle.
- **Minimum spacing:** 3 cycles between accepted commands. A new command may be accepted in the same cycle as `rsp_valid`.
- **Wait states:** each cycle of `pready = 0` in ACCESS adds one cycle of latency.
- **Timeout:** abort at the edge ending the `TIMEOUT`-th consecutive ACCESS cycle with `pready` low. If `pready` rises on that same edge, completion wins and `rsp_timeout = 0`.
- **Reset mid-transfer:** `psel`/`penable` drop asynchronously and no `rsp_valid` is issued for the aborted transfer.

## Structure

- Shared package `apb_pkg`:
  - `typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t` (shared with slave models);
  - localparams `APB_ADDR_W = 32` and `APB_DATA_W = 8`.
- One sub-module, `apb_wait_timer`: a saturating wait-state counter with `clear`, `inc` and a `expired` output.
- The FSM and datapath registers live in `apb_master`.

## Test plan

- **Write, zero wait:** write addr 3, data 0xA5, `pready` tied high → `psel` rises 1 cycle after accept, `penable` 2 cycles after, `rsp_valid` 3 cycles after with `rsp_err = 0`, `rsp_rdata = 0x00`.
- **Read-back:** read addr 3 from the 16-entry slave → `rsp_rdata = 0xA5`, `rsp_err = 0`; `pwrite = 0` throughout SETUP/ACCESS.
- **Slave error:** write addr 20 → slave asserts `pslverr` with `pready` → `rsp_err = 1`, `rsp_timeout = 0`.
- **Wait states:** hold `pready` low for 3 ACCESS cycles on a read of addr 7 → `rsp_valid` 6 cycles after accept; `paddr = 7` stable throughout; `cmd_valid` pulsed mid-transfer is ignored (`cmd_ready = 0`).
- **Timeout:** `TIMEOUT = 16`, `pready` stuck low → abort after 16 ACCESS cycles; `rsp_err = 1`, `rsp_timeout = 1`, `rsp_rdata = 0`, `psel = 0` next cycle. Repeat with `pready` rising on cycle 16 → normal completion.
- **Reset in ACCESS:** assert `prst = 0` → `psel`, `penable` and all `rsp_*` outputs go to 0 immediately with no `rsp_valid`; after release, a write to addr 1 completes normally.
